// File: rtl/iob_eth_pkg.sv
// Shared definitions for the IOb-to-Wishbone bridge: FSM encodings and the
// read-data value returned when a transfer fails.
package iob_eth_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_DONE = 2'd2
   } wb_state_e;

   localparam int unsigned ERR_RDATA_W = 32;
   localparam logic [ERR_RDATA_W-1:0] ERR_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/iob_wb_timeout.sv
// Wishbone wait counter: counts enabled cycles and flags the cycle whose
// increment lands on the all-ones value.
module iob_wb_timeout #(
   parameter int unsigned TIMEOUT_W = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire_c
);

   localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

   logic [TIMEOUT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + TIMEOUT_W'(1);
      end
   end

   assign o_expire_c = i_en && (r_cnt == (CNT_MAX - TIMEOUT_W'(1)));

endmodule

// File: rtl/iob_wb_bridge.sv
// Single-outstanding IOb-to-Wishbone master bridge with wait timeout and
// sticky bus/timeout error flags.
module iob_wb_bridge
   import iob_eth_pkg::*;
#(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned TIMEOUT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid,
   input  logic [ADDR_W-1:0]   address,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   output logic [DATA_W-1:0]   rdata,
   output logic                ready,
   output logic [ADDR_W-3:0]   wb_adr_o,
   output logic [DATA_W/8-1:0] wb_sel_o,
   output logic                wb_we_o,
   output logic                wb_cyc_o,
   output logic                wb_stb_o,
   output logic [DATA_W-1:0]   wb_dat_o,
   input  logic [DATA_W-1:0]   wb_dat_i,
   input  logic                wb_ack_i,
   input  logic                wb_err_i,
   input  logic                err_clr_i,
   output logic                busy_o,
   output logic                bus_err_o,
   output logic                tmo_err_o
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned WADR_W = ADDR_W - 2;

   wb_state_e          r_state,   w_state_nxt;
   logic [WADR_W-1:0]  r_adr,     w_adr_nxt;
   logic [STRB_W-1:0]  r_sel,     w_sel_nxt;
   logic               r_we,      w_we_nxt;
   logic               r_cyc,     w_cyc_nxt;
   logic [DATA_W-1:0]  r_dat,     w_dat_nxt;
   logic [DATA_W-1:0]  r_rdata,   w_rdata_nxt;
   logic               r_ready,   w_ready_nxt;
   logic               r_busy,    w_busy_nxt;
   logic               r_bus_err, w_bus_err_nxt;
   logic               r_tmo_err, w_tmo_err_nxt;
   logic               w_tmo_en;
   logic               w_tmo_clr;
   logic               w_tmo_expire_c;
   logic               w_unused;

   // Byte offset bits are dropped: the slave is word addressed.
   assign w_unused = &{1'b0, address[1:0]};

   iob_wb_timeout #(
      .TIMEOUT_W (TIMEOUT_W)
   ) u_timeout (
      .clk        (clk),
      .rst        (rst),
      .i_clr      (w_tmo_clr),
      .i_en       (w_tmo_en),
      .o_expire_c (w_tmo_expire_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_adr     <= '0;
         r_sel     <= '0;
         r_we      <= 1'b0;
         r_cyc     <= 1'b0;
         r_dat     <= '0;
         r_rdata   <= '0;
         r_ready   <= 1'b0;
         r_busy    <= 1'b0;
         r_bus_err <= 1'b0;
         r_tmo_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_adr     <= w_adr_nxt;
         r_sel     <= w_sel_nxt;
         r_we      <= w_we_nxt;
         r_cyc     <= w_cyc_nxt;
         r_dat     <= w_dat_nxt;
         r_rdata   <= w_rdata_nxt;
         r_ready   <= w_ready_nxt;
         r_busy    <= w_busy_nxt;
         r_bus_err <= w_bus_err_nxt;
         r_tmo_err <= w_tmo_err_nxt;
      end
   end

   // Next-state and next-output logic; a flag set in the same cycle as a clear wins.
   always_comb begin
      w_state_nxt   = r_state;
      w_adr_nxt     = r_adr;
      w_sel_nxt     = r_sel;
      w_we_nxt      = r_we;
      w_cyc_nxt     = r_cyc;
      w_dat_nxt     = r_dat;
      w_rdata_nxt   = r_rdata;
      w_ready_nxt   = 1'b0;
      w_busy_nxt    = r_busy;
      w_bus_err_nxt = err_clr_i ? 1'b0 : r_bus_err;
      w_tmo_err_nxt = err_clr_i ? 1'b0 : r_tmo_err;
      w_tmo_en      = 1'b0;
      w_tmo_clr     = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            w_tmo_clr = 1'b1;
            if (valid) begin
               w_state_nxt = ST_BUS;
               w_adr_nxt   = address[ADDR_W-1:2];
               w_dat_nxt   = wdata;
               w_we_nxt    = |wstrb;
               w_sel_nxt   = (|wstrb) ? wstrb : '1;
               w_cyc_nxt   = 1'b1;
               w_busy_nxt  = 1'b1;
            end
         end
         ST_BUS: begin
            w_tmo_en = 1'b1;
            if (wb_err_i) begin
               w_state_nxt   = ST_DONE;
               w_cyc_nxt     = 1'b0;
               w_ready_nxt   = 1'b1;
               w_rdata_nxt   = DATA_W'(ERR_RDATA);
               w_bus_err_nxt = 1'b1;
            end else if (wb_ack_i) begin
               w_state_nxt = ST_DONE;
               w_cyc_nxt   = 1'b0;
               w_ready_nxt = 1'b1;
               if (!r_we) begin
                  w_rdata_nxt = wb_dat_i;
               end
            end else if (w_tmo_expire_c) begin
               w_state_nxt   = ST_DONE;
               w_cyc_nxt     = 1'b0;
               w_ready_nxt   = 1'b1;
               w_rdata_nxt   = DATA_W'(ERR_RDATA);
               w_tmo_err_nxt = 1'b1;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cyc_nxt   = 1'b0;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   assign rdata     = r_rdata;
   assign ready     = r_ready;
   assign wb_adr_o  = r_adr;
   assign wb_sel_o  = r_sel;
   assign wb_we_o   = r_we;
   assign wb_cyc_o  = r_cyc;
   assign wb_stb_o  = r_cyc;
   assign wb_dat_o  = r_dat;
   assign busy_o    = r_busy;
   assign bus_err_o = r_bus_err;
   assign tmo_err_o = r_tmo_err;

endmodule
